// File: rtl/trace_pkg.sv
// Shared types for the commit tracer: the trace record layout and record-kind encodings.
package trace_pkg;

    localparam logic KIND_GRF = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  byteen;
    } trace_rec_t;

    // Zero every data byte whose byte-enable bit is clear.
    function automatic logic [31:0] mask_bytes(input logic [31:0] data, input logic [3:0] byteen);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = byteen[i] ? data[i*8 +: 8] : 8'h00;
        end
        return res;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Two-write / one-read FIFO of trace records. Writes are in slot order: slot 1 is only used
// alongside slot 0. The caller guarantees that no write overruns the FIFO.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  wr_vld_i,
    input  trace_rec_t  wr_rec0_i,
    input  trace_rec_t  wr_rec1_i,
    input  logic        pop_i,
    output logic [AW:0] count_o,
    output trace_rec_t  head_o
);

    trace_rec_t    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   wr_cnt;

    always_comb begin
        wr_cnt  = (AW+1)'(wr_vld_i[0]) + (AW+1)'(wr_vld_i[1]);
        wptr_d  = wptr_q + AW'(wr_cnt);
        rptr_d  = rptr_q + AW'(pop_i);
        count_d = count_q + wr_cnt - (AW+1)'(pop_i);
    end

    // NOTE: every register is assigned with <= so all updates see the pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array has no reset; stale entries are invisible while count is zero.
    always_ff @(posedge clk) begin
        if (wr_vld_i[0]) mem_q[wptr_q] <= wr_rec0_i;
        if (wr_vld_i[1]) mem_q[wptr_q + AW'(1)] <= wr_rec1_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/commit_tracer.sv
// Commit-trace recorder: turns GRF write-back and store events into ordered trace records.
// Optional build macro TRACE_DROP_R0_EN suppresses GRF writes to register $0.
module commit_tracer
    import trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w_grf_we,
    input  logic [4:0]       w_grf_addr,
    input  logic [31:0]      w_grf_wdata,
    input  logic [31:0]      w_inst_addr,
    input  logic [31:0]      m_data_addr,
    input  logic [31:0]      m_data_wdata,
    input  logic [3:0]       m_data_byteen,
    input  logic [31:0]      m_inst_addr,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic             rec_kind,
    output logic [31:0]      rec_pc,
    output logic [31:0]      rec_addr,
    output logic [31:0]      rec_data,
    output logic [3:0]       rec_byteen,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 2;

    logic             grf_ev, mem_ev, grf_acc, mem_acc, pop;
    trace_rec_t       grf_rec, mem_rec, wr_rec0, head, head_vis;
    logic [1:0]       wr_vld, n_drop;
    logic [AW:0]      count;
    logic [FW-1:0]    free, need_mem;
    logic [CNT_W:0]   drop_sum;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

`ifdef TRACE_DROP_R0_EN
    assign grf_ev = w_grf_we && (w_grf_addr != 5'd0);
`else
    assign grf_ev = w_grf_we;
`endif
    assign mem_ev = |m_data_byteen;

    assign grf_rec = '{kind: KIND_GRF, pc: w_inst_addr, addr: {27'd0, w_grf_addr},
                       data: w_grf_wdata, byteen: 4'hF};
    assign mem_rec = '{kind: KIND_MEM, pc: m_inst_addr, addr: m_data_addr & 32'hFFFF_FFFC,
                       data: mask_bytes(m_data_wdata, m_data_byteen), byteen: m_data_byteen};

    assign rec_valid = (count != '0);
    assign pop       = rec_valid && rec_ready;

    // A same-cycle pop frees a slot; the older GRF event claims space before MEM.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        free     = FW'(DEPTH) - FW'(count) + FW'(pop);
        need_mem = grf_ev ? FW'(2) : FW'(1);
        grf_acc  = grf_ev && (free >= FW'(1));
        mem_acc  = mem_ev && (free >= need_mem);
        wr_vld   = {grf_acc && mem_acc, grf_acc || mem_acc};
        wr_rec0  = grf_acc ? grf_rec : mem_rec;
        n_drop   = 2'(grf_ev && !grf_acc) + 2'(mem_ev && !mem_acc);
        drop_sum = {1'b0, drop_cnt_q} + (CNT_W+1)'(n_drop);
        drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        overflow_d = overflow_q || (n_drop != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_vld_i  (wr_vld),
        .wr_rec0_i (wr_rec0),
        .wr_rec1_i (mem_rec),
        .pop_i     (pop),
        .count_o   (count),
        .head_o    (head)
    );

    assign head_vis   = rec_valid ? head : '0;
    assign rec_kind   = head_vis.kind;
    assign rec_pc     = head_vis.pc;
    assign rec_addr   = head_vis.addr;
    assign rec_data   = head_vis.data;
    assign rec_byteen = head_vis.byteen;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_commit_tracer.sv
// Scoreboard bench for commit_tracer: stimulus pushes hand-computed records, a monitor pops
// and compares on every accepted record.
module tb_commit_tracer;
    import trace_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        w_grf_we = 1'b0;
    logic [4:0]  w_grf_addr = '0;
    logic [31:0] w_grf_wdata = '0, w_inst_addr = '0;
    logic [31:0] m_data_addr = '0, m_data_wdata = '0, m_inst_addr = '0;
    logic [3:0]  m_data_byteen = '0;
    logic        rec_ready = 1'b1;
    logic        rec_valid, rec_kind, overflow;
    logic [31:0] rec_pc, rec_addr, rec_data;
    logic [3:0]  rec_byteen;
    logic [15:0] drop_cnt;

    trace_rec_t exp_q[$];
    trace_rec_t mon_exp;
    int n_checks = 0;
    int n_errors = 0;

    commit_tracer #(.DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr), .w_grf_wdata(w_grf_wdata),
        .w_inst_addr(w_inst_addr),
        .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
        .rec_pc(rec_pc), .rec_addr(rec_addr), .rec_data(rec_data), .rec_byteen(rec_byteen),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare each record the sink accepts against the oldest expected one.
    always @(negedge clk) begin
        if (reset && rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_record: got pc %h expected none", rec_pc);
            end else begin
                mon_exp = exp_q.pop_front();
                check("record", 128'({rec_kind, rec_pc, rec_addr, rec_data, rec_byteen}),
                      128'(mon_exp));
            end
        end
    end

    task automatic push(input logic kind, input logic [31:0] pc, addr, data, input logic [3:0] be);
        exp_q.push_back('{kind: kind, pc: pc, addr: addr, data: data, byteen: be});
    endtask

    // Present one cycle of events, then clear them; returns 1 ns after the sampling edge.
    task automatic ev(input logic gwe, input logic [4:0] ga, input logic [31:0] gd, gpc,
                      input logic [3:0] be, input logic [31:0] ma, md, mpc);
        w_grf_we = gwe; w_grf_addr = ga; w_grf_wdata = gd; w_inst_addr = gpc;
        m_data_byteen = be; m_data_addr = ma; m_data_wdata = md; m_inst_addr = mpc;
        @(posedge clk); #1;
        w_grf_we = 1'b0; w_grf_addr = '0; w_grf_wdata = '0; w_inst_addr = '0;
        m_data_byteen = '0; m_data_addr = '0; m_data_wdata = '0; m_inst_addr = '0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !rec_valid) break;
            @(posedge clk); #1;
        end
        check({name, "_left"}, 128'(exp_q.size()), 128'(0));
        check({name, "_valid"}, 128'(rec_valid), 128'(0));
    endtask

    initial begin
        // Reset held for two edges, then released with no events.
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("rst_rec", 128'({rec_valid, rec_kind, rec_pc, rec_addr, rec_data, rec_byteen}), 128'(0));
        check("rst_ovf", 128'(overflow), 128'(0));
        check("rst_drop", 128'(drop_cnt), 128'(0));

        // Single GRF write, no bypass: record visible after the sampling edge, then gone.
        push(KIND_GRF, 32'h3004, 32'h5, 32'h1234_5678, 4'hF);
        ev(1'b1, 5'd5, 32'h1234_5678, 32'h3004, 4'h0, 32'h0, 32'h0, 32'h0);
        check("single_valid", 128'(rec_valid), 128'(1));
        @(posedge clk); #1;
        check("single_empty", 128'(rec_valid), 128'(0));
        check("idle_pc_zero", 128'(rec_pc), 128'(0));

        // Dual event: GRF first, then the aligned and masked store.
        push(KIND_GRF, 32'h3008, 32'h8, 32'h0000_0088, 4'hF);
        push(KIND_MEM, 32'h300C, 32'h10, 32'h00BB_0000, 4'b0100);
        ev(1'b1, 5'd8, 32'h88, 32'h3008, 4'b0100, 32'h13, 32'hAABB_CCDD, 32'h300C);
        wait_drain("dual", 10);

        // A store with no byte enables is not an event.
        ev(1'b0, 5'd3, 32'h1, 32'h3010, 4'b0000, 32'h20, 32'hFFFF_FFFF, 32'h3014);
        check("no_byteen_valid", 128'(rec_valid), 128'(0));
        check("no_byteen_drop", 128'(drop_cnt), 128'(0));

        // Fill under back-pressure: 4 dual cycles fill 8 slots, the 5th drops both.
        rec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                push(KIND_GRF, 32'h200 + 8*i, 32'(i + 1), 32'h1000 + i, 4'hF);
                push(KIND_MEM, 32'h204 + 8*i, 32'h400 + 4*i, 32'hA000 + i, 4'hF);
            end
            ev(1'b1, 5'(i + 1), 32'h1000 + i, 32'h200 + 8*i,
               4'hF, 32'h400 + 4*i, 32'hA000 + i, 32'h204 + 8*i);
        end
        check("full_ovf", 128'(overflow), 128'(1));
        check("full_drop", 128'(drop_cnt), 128'(2));
        check("stall_pc0", 128'(rec_pc), 128'(32'h200));
        @(posedge clk); #1;
        check("stall_pc1", 128'(rec_pc), 128'(32'h200));
        check("stall_valid", 128'(rec_valid), 128'(1));

        // Full FIFO with a same-cycle pop: only the GRF event fits.
        rec_ready = 1'b1;
        push(KIND_GRF, 32'h300, 32'h9, 32'h99, 4'hF);
        ev(1'b1, 5'd9, 32'h99, 32'h300, 4'b0001, 32'h500, 32'h55, 32'h304);
        check("fullpop_drop", 128'(drop_cnt), 128'(3));
        check("fullpop_ovf", 128'(overflow), 128'(1));
        wait_drain("fill", 40);

        // Write to $0.
`ifdef TRACE_DROP_R0_EN
        ev(1'b1, 5'd0, 32'hDEAD, 32'h3010, 4'h0, 32'h0, 32'h0, 32'h0);
        check("r0_valid", 128'(rec_valid), 128'(0));
        check("r0_drop", 128'(drop_cnt), 128'(3));
`else
        push(KIND_GRF, 32'h3010, 32'h0, 32'hDEAD, 4'hF);
        ev(1'b1, 5'd0, 32'hDEAD, 32'h3010, 4'h0, 32'h0, 32'h0, 32'h0);
        check("r0_valid", 128'(rec_valid), 128'(1));
        wait_drain("r0", 10);
`endif

        // Reset during a drain discards entries and clears the sticky state.
        rec_ready = 1'b0;
        push(KIND_GRF, 32'h600, 32'h3, 32'h33, 4'hF);
        push(KIND_MEM, 32'h604, 32'h804, 32'h0000_3344, 4'b0011);
        push(KIND_GRF, 32'h608, 32'h4, 32'h44, 4'hF);
        ev(1'b1, 5'd3, 32'h33, 32'h600, 4'b0011, 32'h804, 32'h1122_3344, 32'h604);
        ev(1'b1, 5'd4, 32'h44, 32'h608, 4'h0, 32'h0, 32'h0, 32'h0);
        check("pre_rst_ovf", 128'(overflow), 128'(1));
        rec_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        check("mid_rst_valid", 128'(rec_valid), 128'(0));
        check("mid_rst_rec", 128'({rec_kind, rec_pc, rec_addr, rec_data, rec_byteen}), 128'(0));
        check("mid_rst_ovf", 128'(overflow), 128'(0));
        check("mid_rst_drop", 128'(drop_cnt), 128'(0));

        push(KIND_GRF, 32'h700, 32'h7, 32'h77, 4'hF);
        ev(1'b1, 5'd7, 32'h77, 32'h700, 4'h0, 32'h0, 32'h0, 32'h0);
        check("post_rst_valid", 128'(rec_valid), 128'(1));
        wait_drain("post_rst", 10);
        check("post_rst_ovf", 128'(overflow), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
